// File: rtl/rv32_isa_pkg.sv
// rv32_isa_pkg
//   Shared RV32I definitions for the instruction-memory boot loader and
//   the decode stage: the nine supported major opcodes, an opcode
//   membership test and the loader state encoding.
package rv32_isa_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  function automatic logic is_supported_opcode(input logic [6:0] opc);
    logic ok;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: ok = 1'b1;
      default:                                 ok = 1'b0;
    endcase
    return ok;
  endfunction

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN_LO,
    LD_LEN_HI,
    LD_BYTE,
    LD_WRITE,
    LD_DONE,
    LD_ERR
  } loader_state_t;

endpackage

// File: rtl/byte_word_packer.sv
// byte_word_packer
//   Collects four bytes, least significant first, into a 32-bit word.
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     clr          clears the byte counter (start of a new load)
//     byte_en      accept byte_in this cycle
//     byte_in      incoming byte
//     word         assembled word (shift register contents)
//     word_ready   high in the cycle the 4th byte of a word is accepted
module byte_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clr) begin
      cnt_q  <= '0;
    end else if (byte_en) begin
      // Shifting in from the top leaves the first byte in [7:0] after four accepts.
      word_q <= {byte_in, word_q[31:8]};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  assign word       = word_q;
  assign word_ready = byte_en && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Receives a framed byte stream (16-bit LE word count N, then 4*N
//   instruction bytes, LSB first), writes the words sequentially into
//   instruction memory from address 0 and holds the CPU in reset until
//   the load has completed.
//   Optional build macro: IMEM_OPCODE_CHECK_EN -- reject words whose
//   opcode field is not a supported RV32I major opcode.
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     start                 one-cycle pulse, begins a load from IDLE/DONE/ERR
//     in_valid/in_data      incoming byte stream
//     in_ready              a byte can be accepted this cycle (registered)
//     imem_we/addr/wdata    IMEM write port, one strobe per word
//     cpu_hold              keeps the CPU in reset (low only in DONE)
//     done, error           sticky load status
//     word_count            words written in the current load
//   ADDR_WIDTH must be in 1..16 (N is a 16-bit count).
module imem_boot_loader
  import rv32_isa_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int unsigned  CNT_W    = ADDR_WIDTH + 1;
  localparam logic [16:0]  CAPACITY = 17'(1) << ADDR_WIDTH;

  loader_state_t state_q, state_d;

  logic             in_ready_q, in_ready_d;
  logic [15:0]      n_q;
  logic [CNT_W-1:0] wc_q;
  logic [CNT_W-1:0] wc_next;
  logic [15:0]      len_full;
  logic             accept;
  logic             clr_load;
  logic             wc_inc;
  logic             byte_en;
  logic [31:0]      word;
  logic             word_ready;
  logic             opcode_ok;

  assign accept   = in_valid && in_ready_q;
  assign byte_en  = accept && (state_q == LD_BYTE);
  assign len_full = {in_data, n_q[7:0]};
  assign wc_next  = wc_q + {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef IMEM_OPCODE_CHECK_EN
  assign opcode_ok = is_supported_opcode(word[6:0]);
`else
  assign opcode_ok = 1'b1;
`endif

  byte_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr_load),
    .byte_en    (byte_en),
    .byte_in    (in_data),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= LD_IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    imem_we  = 1'b0;
    clr_load = 1'b0;
    wc_inc   = 1'b0;
    case (state_q)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (start) begin
          state_d  = LD_LEN_LO;
          clr_load = 1'b1;
        end
      end
      LD_LEN_LO: begin
        if (accept) state_d = LD_LEN_HI;
      end
      LD_LEN_HI: begin
        if (accept) begin
          if (len_full == 16'd0)                state_d = LD_DONE;
          else if ({1'b0, len_full} > CAPACITY) state_d = LD_ERR;
          else                                  state_d = LD_BYTE;
        end
      end
      LD_BYTE: begin
        if (word_ready) state_d = LD_WRITE;
      end
      LD_WRITE: begin
        if (opcode_ok) begin
          imem_we = 1'b1;
          wc_inc  = 1'b1;
          state_d = (17'(wc_next) == {1'b0, n_q}) ? LD_DONE : LD_BYTE;
        end else begin
          state_d = LD_ERR;
        end
      end
      default: state_d = LD_IDLE;
    endcase
    // Registered from the next state so in_ready never depends on in_valid
    // within a cycle, yet still matches the state it is presented in.
    in_ready_d = (state_d == LD_LEN_LO) || (state_d == LD_LEN_HI) ||
                 (state_d == LD_BYTE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_q  <= '0;
      wc_q <= '0;
    end else begin
      if (accept && (state_q == LD_LEN_LO)) n_q[7:0]  <= in_data;
      if (accept && (state_q == LD_LEN_HI)) n_q[15:8] <= in_data;
      if (clr_load)    wc_q <= '0;
      else if (wc_inc) wc_q <= wc_next;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_addr  = wc_q[ADDR_WIDTH-1:0];
  assign imem_wdata = word;
  assign cpu_hold   = (state_q != LD_DONE);
  assign done       = (state_q == LD_DONE);
  assign error      = (state_q == LD_ERR);
  assign word_count = wc_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [10:0] word_count;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [63:0] sb_q[$];

  imem_boot_loader #(.ADDR_WIDTH(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every IMEM write must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_write", {22'b0, imem_addr, imem_wdata}, 64'hDEAD);
      end else begin
        check_eq("write_addr_data", {22'b0, imem_addr, imem_wdata}, sb_q.pop_front());
        check_eq("ready_in_write", {63'b0, in_ready}, 64'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Presents a byte and returns #1 after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 40) begin
      cyc();
      n++;
    end
    if (!in_ready) check_eq("ready_timeout", {63'b0, in_ready}, 64'd1);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  // gappy: idle cycle (with a start pulse that must be ignored) between bytes.
  task automatic send_word(input logic [31:0] w, input bit exp_wr,
                           input logic [9:0] addr, input bit gappy);
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && exp_wr) sb_q.push_back({22'b0, addr, w});
      send_byte(w[8*i +: 8]);
      if (gappy && i < 3) begin
        start = 1'b1;
        cyc();
        start = 1'b0;
      end
    end
    check_eq("we_latency", {63'b0, imem_we}, {63'b0, exp_wr});
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_ready"}, {63'b0, in_ready}, 64'd0);
    check_eq({pfx, "_we"},    {63'b0, imem_we},  64'd0);
    check_eq({pfx, "_addr"},  {54'b0, imem_addr}, 64'd0);
    check_eq({pfx, "_wdata"}, {32'b0, imem_wdata}, 64'd0);
    check_eq({pfx, "_hold"},  {63'b0, cpu_hold}, 64'd1);
    check_eq({pfx, "_done"},  {63'b0, done},     64'd0);
    check_eq({pfx, "_error"}, {63'b0, error},    64'd0);
    check_eq({pfx, "_wc"},    {53'b0, word_count}, 64'd0);
  endtask

  task automatic check_status(input string pfx, input bit d, input bit e, input int unsigned wc);
    check_eq({pfx, "_done"},  {63'b0, done},     {63'b0, d});
    check_eq({pfx, "_error"}, {63'b0, error},    {63'b0, e});
    check_eq({pfx, "_hold"},  {63'b0, cpu_hold}, {63'b0, ~d});
    check_eq({pfx, "_wc"},    {53'b0, word_count}, 64'(wc));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) cyc();
    check_reset_vals("rst");
    rst_n = 1'b1;
    cyc();

    // Two-word program
    pulse_start();
    send_len(16'd2);
    send_word(32'h00A00513, 1'b1, 10'd0, 1'b0);
    send_word(32'h0000006F, 1'b1, 10'd1, 1'b0);
    cyc();
    check_status("two_word", 1'b1, 1'b0, 2);

    // Empty program: DONE right at the second length byte
    pulse_start();
    check_status("restart", 1'b0, 1'b0, 0);
    send_len(16'd0);
    check_status("n0", 1'b1, 1'b0, 0);

    // Oversize N
    pulse_start();
    send_len(16'h0401);
    check_status("oversize", 1'b0, 1'b1, 0);
    check_eq("oversize_ready", {63'b0, in_ready}, 64'd0);
    pulse_start();
    check_eq("err_cleared", {63'b0, error}, 64'd0);
    send_len(16'd1);
    send_word(32'h00001237, 1'b1, 10'd0, 1'b0);
    cyc();
    check_status("after_err", 1'b1, 1'b0, 1);

    // Gapped valid with ignored start pulses mid-word
    pulse_start();
    send_len(16'd1);
    send_word(32'h00000033, 1'b1, 10'd0, 1'b1);
    cyc();
    check_status("gappy", 1'b1, 1'b0, 1);

    // Reset in the middle of word 1 of a 3-word load
    pulse_start();
    send_len(16'd3);
    send_word(32'h00500093, 1'b1, 10'd0, 1'b0);
    send_byte(8'h13);
    send_byte(8'h01);
    rst_n = 1'b0;
    cyc();
    check_reset_vals("midrst");
    cyc();
    rst_n = 1'b1;
    cyc();
    pulse_start();
    send_len(16'd1);
    send_word(32'h00000013, 1'b1, 10'd0, 1'b0);
    cyc();
    check_status("post_rst", 1'b1, 1'b0, 1);

    // Bad opcode in word 1
    pulse_start();
    send_len(16'd2);
    send_word(32'h00000013, 1'b1, 10'd0, 1'b0);
`ifdef IMEM_OPCODE_CHECK_EN
    send_word(32'hFFFFFFFF, 1'b0, 10'd1, 1'b0);
    cyc();
    check_status("bad_opc", 1'b0, 1'b1, 1);
`else
    send_word(32'hFFFFFFFF, 1'b1, 10'd1, 1'b0);
    cyc();
    check_status("bad_opc", 1'b1, 1'b0, 2);
`endif

    // Full-capacity load: N == 2^ADDR_WIDTH is accepted
    pulse_start();
    send_len(16'h0400);
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w = (32'(i) << 8) | 32'h13;
      send_word(w, 1'b1, 10'(i), 1'b0);
    end
    cyc();
    check_status("full", 1'b1, 1'b0, 1024);

    repeat (2) cyc();
    check_eq("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

- Receives a byte stream from the host link (UART receiver side) and assembles it into little-endian 32-bit RV32I instruction words.
- Writes each word sequentially into instruction memory, starting at word address 0.
- Holds the pipelined CPU in reset until a complete program has been loaded.
- It is the writer of the words that the fetch stage and control unit later read and decode.

## Interface
Parameters:
- ADDR_WIDTH, 10, IMEM word-address width; capacity 2^ADDR_WIDTH words

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERR
- in_valid  in  1  input byte valid
- in_data  in  8  input byte
- in_ready  out  1  loader can accept a byte this cycle
- imem_we  out  1  IMEM write strobe, one cycle per word
- imem_addr  out  ADDR_WIDTH  IMEM word address
- imem_wdata  out  32  assembled instruction word
- cpu_hold  out  1  high keeps the CPU in reset
- done  out  1  load completed successfully (sticky)
- error  out  1  load aborted (sticky)
- word_count  out  ADDR_WIDTH+1  words written in the current load

## Operation
- Frame format: 2-byte little-endian word count N, followed by 4·N instruction bytes, least significant byte first.
- States:
  - IDLE: in_ready=0. start -> LEN_LO.
  - LEN_LO: accept byte -> N[7:0]; -> LEN_HI.
  - LEN_HI: accept byte -> N[15:8]. Then:
    - N==0 -> DONE.
    - N > 2^ADDR_WIDTH -> ERR.
    - otherwise -> BYTE.
  - BYTE: accept bytes into a shift register with a byte counter 0..3. The 4th accept -> WRITE.
  - WRITE: imem_we=1 for one cycle, imem_addr=word_count[ADDR_WIDTH-1:0], in_ready=0. Then word_count+1. If word_count+1==N -> DONE, else -> BYTE.
  - DONE: done=1, cpu_hold=0. start -> LEN_LO, which clears done, word_count and the byte counter.
  - ERR: error=1, cpu_hold=1. start -> LEN_LO, which clears error.
- A byte is accepted only when in_valid && in_ready. in_ready=1 only in LEN_LO, LEN_HI and BYTE.
- start is ignored in LEN_LO, LEN_HI, BYTE and WRITE.
- cpu_hold=1 in every state except DONE.

## Timing
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0, word_count=0.
- Asserting rst_n low in any state (including mid-word or WRITE) returns the block to IDLE on the next edge. The partial word is discarded and no write is issued.
- in_ready is registered from state and depends on no inputs, so there is no combinational path from in_valid to in_ready.
- Latency: imem_we asserts exactly 1 cycle after the edge that accepts the 4th byte of a word.
- Throughput: at most one word per 5 cycles.
- In the cycle word_count reaches N, the state becomes DONE and cpu_hold falls on the same edge.
- word_count holds its final value in DONE and ERR.

## Configuration
- IMEM_OPCODE_CHECK_EN defined:
  - In WRITE, bits [6:0] of the word are checked against the supported opcode set: 0000011, 0010011, 0010111, 0100011, 0110011, 0110111, 1100011, 1100111, 1101111.
  - An unsupported opcode suppresses imem_we and moves the block to ERR. word_count does not increment.
- IMEM_OPCODE_CHECK_EN undefined: every word is written unchecked and ERR is reachable only through an oversize N.

## Structure
- Shared package rv32_isa_pkg holds:
  - the nine opcode localparams (shared with the decode stage);
  - the function is_supported_opcode;
  - the loader state enum.
- Sub-module byte_word_packer (byte shift register, 2-bit counter, word_ready pulse) is natural. The FSM, address counter and IMEM interface stay in the top module.

## Test plan
- Reset then start; send bytes 02 00, 13 05 A0 00, 6F 00 00 00 -> two writes: addr 0 data 0x00A00513, then addr 1 data 0x0000006F. done=1, cpu_hold=0, word_count=2.
- Load with N=0 (bytes 00 00) -> no imem_we, DONE within 1 cycle of the second byte, done=1.
- Load with N=0x0401 at ADDR_WIDTH=10 -> ERR after LEN_HI, error=1, cpu_hold=1, no writes. A subsequent start followed by a valid 1-word frame reaches DONE.
- N=1 with in_valid toggling every other cycle over bytes 33 00 00 00 -> one write of 0x00000033, with no duplicated or dropped bytes.
- Assert rst_n low after 2 bytes of word 1 (of N=3) -> no write for that word, outputs return to reset values. A fresh load succeeds from addr 0.
- With IMEM_OPCODE_CHECK_EN, N=2 frame with word 1 = 0xFFFFFFFF -> word 0 written, word 1 not written, ERR, word_count=1. Without the macro the same frame reaches DONE with word_count=2.
